// File: rtl/lisa_int_alu_mc.sv
// lisa_int_alu_mc: integer ALU, 1-cycle ADD/SUB, iterative shift-add MUL.
// Define LISA_INT_ALU_MC_FAST_MUL_EN for a single-cycle combinational MUL.
module lisa_int_alu_mc #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TAG_W   = 4,
   parameter logic [4:0]  UOP_ADD = 5'd0,
   parameter logic [4:0]  UOP_SUB = 5'd1,
   parameter logic [4:0]  UOP_MUL = 5'd2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_uop,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_y_q, out_y_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic [WIDTH-1:0] quick_y;
   logic             accept;

   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_tag   = out_tag_q;

   // Unrecognised uops fall through to zero
   always_comb begin
      quick_y = '0;
      if (in_uop == UOP_ADD) begin
         quick_y = in_a + in_b;
      end else if (in_uop == UOP_SUB) begin
         quick_y = in_a - in_b;
`ifdef LISA_INT_ALU_MC_FAST_MUL_EN
      end else if (in_uop == UOP_MUL) begin
         quick_y = in_a * in_b;
`endif
      end
   end

`ifdef LISA_INT_ALU_MC_FAST_MUL_EN

   assign in_ready = !rst && (!out_valid_q || out_ready);
   assign busy     = out_valid_q;

   always_comb begin
      out_valid_d = out_valid_q && !out_ready;
      out_y_d     = out_y_q;
      out_tag_d   = out_tag_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_y_d     = quick_y;
         out_tag_d   = in_tag;
      end
   end

`else

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [TAG_W-1:0] tag_q, tag_d;

   assign in_ready = !rst && (state_q == S_IDLE)
                     && (!out_valid_q || out_ready);
   assign busy     = (state_q != S_IDLE) || out_valid_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q && !out_ready;
      out_y_d     = out_y_q;
      out_tag_d   = out_tag_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (in_uop == UOP_MUL) begin
                  state_d  = S_MUL;
                  cnt_d    = '0;
                  mcand_d  = in_a;
                  mplier_d = in_b;
                  acc_d    = '0;
                  tag_d    = in_tag;
               end else begin
                  out_valid_d = 1'b1;
                  out_y_d     = quick_y;
                  out_tag_d   = in_tag;
               end
            end
         end
         // Fixed WIDTH steps regardless of operand values
         S_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            out_valid_d = 1'b1;
            out_y_d     = acc_q;
            out_tag_d   = tag_q;
            cnt_d       = '0;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         tag_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         tag_q    <= tag_d;
      end
   end

`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_tag_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_tag_q   <= out_tag_d;
      end
   end

endmodule

// File: tb/tb_lisa_int_alu_mc.sv
// tb_lisa_int_alu_mc: directed and random checks of lisa_int_alu_mc
// against a queue-based arithmetic reference model.
module tb_lisa_int_alu_mc;

   localparam int         W     = 32;
   localparam int         TW    = 4;
   localparam logic [4:0] U_ADD = 5'd0;
   localparam logic [4:0] U_SUB = 5'd1;
   localparam logic [4:0] U_MUL = 5'd2;
`ifdef LISA_INT_ALU_MC_FAST_MUL_EN
   localparam int         MUL_EDGES = 0;
`else
   localparam int         MUL_EDGES = W + 1;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_uop;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_y;
   logic [TW-1:0] out_tag;
   logic          busy;

   int checks = 0;
   int errors = 0;
   bit sb_en  = 1'b0;

   logic [W-1:0]  q_y[$];
   logic [TW-1:0] q_tag[$];
   bit            stall_prev = 1'b0;
   logic [W-1:0]  prev_y;
   logic [TW-1:0] prev_tag;

   lisa_int_alu_mc #(
      .WIDTH   (W),
      .TAG_W   (TW),
      .UOP_ADD (U_ADD),
      .UOP_SUB (U_SUB),
      .UOP_MUL (U_MUL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_uop    (in_uop),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // Reference: plain modular arithmetic on 64-bit integers
   function automatic logic [W-1:0] ref_alu(input logic [4:0] u,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      longint unsigned x, y, m;
      x = 64'(a);
      y = 64'(b);
      m = 64'h1_0000_0000;
      if (u == U_ADD) return W'((x + y) % m);
      if (u == U_SUB) return W'((x + m - y) % m);
      if (u == U_MUL) return W'((x * y) % m);
      return '0;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q_y.delete();
         q_tag.delete();
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold", 64'({out_valid, out_tag, out_y}),
                64'({1'b1, prev_tag, prev_y}));
         end
         if (sb_en) begin
            if (out_valid && out_ready) begin
               chk("sb_nonempty", 64'(q_y.size() != 0), 64'd1);
               if (q_y.size() != 0) begin
                  chk("sb_y", 64'(out_y), 64'(q_y.pop_front()));
                  chk("sb_tag", 64'(out_tag), 64'(q_tag.pop_front()));
               end
            end
            if (in_valid && in_ready) begin
               q_y.push_back(ref_alu(in_uop, in_a, in_b));
               q_tag.push_back(in_tag);
            end
         end
         stall_prev <= out_valid && !out_ready;
         prev_y     <= out_y;
         prev_tag   <= out_tag;
      end
   end

`ifndef LISA_INT_ALU_MC_FAST_MUL_EN
   always @(negedge clk) begin
      if (!rst && dut.state_q == 2'd2) begin
         chk("load_empty", 64'(out_valid), 64'd0);
      end
   end
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [4:0] u, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("issue_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_uop   = u;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      in_tag   = TW'($urandom);
   endtask

   initial begin
      int   edges;
      bit   seen;
      int   r;
      int   n;
      logic [W-1:0] pick [4];

      pick[0] = '0;
      pick[1] = '1;
      pick[2] = 32'h1;
      pick[3] = 32'h8000_0000;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_uop    = '0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_y", 64'(out_y), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      issue(U_ADD, 32'd7, 32'd5, 4'd3);
      chk("add_v", 64'(out_valid), 64'd1);
      chk("add_y", 64'(out_y), 64'd12);
      chk("add_tag", 64'(out_tag), 64'd3);
      chk("add_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("add_drained", 64'(out_valid), 64'd0);

      issue(U_SUB, 32'd0, 32'd1, 4'd1);
      chk("sub_wrap", 64'(out_y), 64'hFFFF_FFFF);
      issue(U_ADD, 32'hFFFF_FFFF, 32'd1, 4'd2);
      chk("add_wrap", 64'(out_y), 64'd0);
      chk("add_wrap_tag", 64'(out_tag), 64'd2);
      issue(5'd17, 32'd9, 32'd9, 4'd4);
      chk("unk_v", 64'(out_valid), 64'd1);
      chk("unk_y", 64'(out_y), 64'd0);

      // MUL while a competing ADD is held on the input
      issue(U_MUL, 32'hFFFF_FFFF, 32'd2, 4'd5);
      in_valid = 1'b1;
      in_uop   = U_ADD;
      in_a     = 32'd1;
      in_b     = 32'd1;
      in_tag   = 4'd9;
      edges    = 0;
      seen     = 1'b0;
      while (!out_valid && edges < 100) begin
         seen |= in_ready;
         @(posedge clk); #1;
         edges++;
      end
      in_valid = 1'b0;
      chk("mul_lat", 64'(edges), 64'(MUL_EDGES));
      chk("mul_y", 64'(out_y), 64'hFFFF_FFFE);
      chk("mul_tag", 64'(out_tag), 64'd5);
      chk("mul_rdy_low", 64'(seen), 64'd0);
      @(posedge clk); #1;
      chk("mul_no_extra", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      issue(U_ADD, 32'd100, 32'd23, 4'd6);
      chk("stall_v", 64'(out_valid), 64'd1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_y", 64'(out_y), 64'd123);
         chk("stall_rdy", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b1;
      in_uop    = U_ADD;
      in_a      = 32'd40;
      in_b      = 32'd2;
      in_tag    = 4'd7;
      out_ready = 1'b1;
      #1;
      chk("drain_acc_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("drain_acc_v", 64'(out_valid), 64'd1);
      chk("drain_acc_y", 64'(out_y), 64'd42);
      chk("drain_acc_tag", 64'(out_tag), 64'd7);
      @(posedge clk); #1;

      // Reset in the middle of an iterative multiply
      issue(U_MUL, 32'd3, 32'd5, 4'd8);
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd0);
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         seen |= out_valid;
         @(posedge clk); #1;
      end
      chk("mrst_no_result", 64'(seen), 64'd0);
      chk("mrst_idle", 64'(busy), 64'd0);
      issue(U_ADD, 32'd20, 32'd22, 4'd10);
      chk("mrst_add_y", 64'(out_y), 64'd42);
      chk("mrst_add_tag", 64'(out_tag), 64'd10);

      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_uop   = U_ADD;
         in_a     = 32'(i * 1000);
         in_b     = 32'(i);
         in_tag   = TW'(i);
         @(posedge clk); #1;
         chk("b2b_v", 64'(out_valid), 64'd1);
         chk("b2b_tag", 64'(out_tag), 64'(i[3:0]));
         chk("b2b_y", 64'(out_y), 64'(i * 1001));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      sb_en = 1'b1;
      repeat (600) begin
         in_valid = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 15);
         if (r < 6)       in_uop = U_ADD;
         else if (r < 12) in_uop = U_SUB;
         else if (r < 14) in_uop = U_MUL;
         else             in_uop = 5'($urandom_range(3, 31));
         in_a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)]
                                            : W'($urandom);
         in_b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)]
                                            : W'($urandom);
         in_tag    = TW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((busy || q_y.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("sb_drained", 64'(q_y.size()), 64'd0);
      chk("end_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
